// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_pkg;

    // Two-state controller: waiting for a request, or stepping through bits.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder, reused over time by the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop process
// the operands LSB first, one bit per clock, behind a start/done handshake.
module serial_addsub
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ovf;
    logic             r_done;

    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;

    // The single adder cell sees the current LSBs and the running carry.
    fa_cell u_fa (
        .a  (r_a[0]),
        .b  (r_b[0]),
        .ci (r_c),
        .s  (w_sum),
        .co (w_cout)
    );

    // Sum bits enter at the MSB so that after WIDTH steps bit 0 lands at index 0.
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    // Controller and datapath: load on accepted start, one bit per RUN edge,
    // publish result/carry/overflow only on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b and seed carry with 1.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_c     <= sub;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_cout;
                    r_res <= w_res_next;
                    if (r_cnt == LAST) begin
                        // r_c is the carry into the MSB here; w_cout is the carry out.
                        r_s     <= w_res_next;
                        r_co    <= w_cout;
                        r_ovf   <= r_c ^ w_cout;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign s    = r_s;
    assign co   = r_co;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH = 8).
module tb_serial_addsub;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       co;
    logic       ovf;

    int n_pass;
    int n_total;

    serial_addsub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Present one request across a single rising edge (edge 0), then drop start.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic isub);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        sub   = isub;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after edge 0 until done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        @(negedge clk);
        n_total++;
        if ({busy, done, s, co, ovf} !== 12'h000)
            $display("FAIL reset_hold: got %h expected 000", {busy, done, s, co, ovf});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({busy, done, s, co, ovf} !== 12'h000)
            $display("FAIL reset_release: got %h expected 000", {busy, done, s, co, ovf});
        else n_pass++;
    endtask

    task automatic test_add_basic();
        int cyc;
        int busy_cyc;
        issue(8'h35, 8'h4A, 1'b0);
        n_total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL basic_busy_rise: got busy=%b done=%b expected busy=1 done=0", busy, done);
        else n_pass++;
        cyc = 0;
        busy_cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1) busy_cyc++;
        end
        n_total++;
        if (cyc !== 8) $display("FAIL basic_latency: got %0d expected 8", cyc);
        else n_pass++;
        n_total++;
        if (busy_cyc !== 8) $display("FAIL basic_busy_cycles: got %0d expected 8", busy_cyc);
        else n_pass++;
        n_total++;
        if ({s, co, ovf} !== {8'h7F, 1'b0, 1'b0})
            $display("FAIL basic_result: got s=%h co=%b ovf=%b expected s=7f co=0 ovf=0", s, co, ovf);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b expected 0", busy);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (done !== 1'b0 || s !== 8'h7F)
            $display("FAIL basic_done_pulse: got done=%b s=%h expected done=0 s=7f", done, s);
        else n_pass++;
    endtask

    task automatic test_add_carry();
        int cyc;
        issue(8'hFF, 8'h01, 1'b0);
        wait_done(cyc);
        n_total++;
        if (cyc !== 8 || {s, co, ovf} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL add_ff_01: got cyc=%0d s=%h co=%b ovf=%b expected cyc=8 s=00 co=1 ovf=0", cyc, s, co, ovf);
        else n_pass++;
        issue(8'h7F, 8'h01, 1'b0);
        wait_done(cyc);
        n_total++;
        if (cyc !== 8 || {s, co, ovf} !== {8'h80, 1'b0, 1'b1})
            $display("FAIL add_7f_01: got cyc=%0d s=%h co=%b ovf=%b expected cyc=8 s=80 co=0 ovf=1", cyc, s, co, ovf);
        else n_pass++;
    endtask

    task automatic test_sub();
        int cyc;
        issue(8'h10, 8'h20, 1'b1);
        wait_done(cyc);
        n_total++;
        if (cyc !== 8 || {s, co, ovf} !== {8'hF0, 1'b0, 1'b0})
            $display("FAIL sub_10_20: got cyc=%0d s=%h co=%b ovf=%b expected cyc=8 s=f0 co=0 ovf=0", cyc, s, co, ovf);
        else n_pass++;
        issue(8'h80, 8'h01, 1'b1);
        wait_done(cyc);
        n_total++;
        if (cyc !== 8 || {s, co, ovf} !== {8'h7F, 1'b1, 1'b1})
            $display("FAIL sub_80_01: got cyc=%0d s=%h co=%b ovf=%b expected cyc=8 s=7f co=1 ovf=1", cyc, s, co, ovf);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int cyc;
        int s_bad;
        int extra;
        // Fresh reset so the held result starts at zero.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        issue(8'h03, 8'h04, 1'b0);
        cyc = 0;
        s_bad = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            if (cyc == 2) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (done !== 1'b1 && s !== 8'h00) s_bad++;
        end
        n_total++;
        if (s_bad !== 0) $display("FAIL ignore_s_held: got %0d disturbed cycles expected 0", s_bad);
        else n_pass++;
        n_total++;
        if (cyc !== 8) $display("FAIL ignore_latency: got %0d expected 8", cyc);
        else n_pass++;
        n_total++;
        if ({s, co, ovf} !== {8'h07, 1'b0, 1'b0})
            $display("FAIL ignore_result: got s=%h co=%b ovf=%b expected s=07 co=0 ovf=0", s, co, ovf);
        else n_pass++;
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_total++;
        if (extra !== 0) $display("FAIL ignore_no_second_op: got %0d active cycles expected 0", extra);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(8'h10, 8'h20, 1'b0);
        wait_done(cyc);
        n_total++;
        if (cyc !== 8 || s !== 8'h30)
            $display("FAIL b2b_first: got cyc=%0d s=%h expected cyc=8 s=30", cyc, s);
        else n_pass++;
        // Still inside the done cycle: request the next operation now.
        start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_no_gap: got busy=%b done=%b expected busy=1 done=0", busy, done);
        else n_pass++;
        wait_done(cyc);
        n_total++;
        if (cyc !== 8) $display("FAIL b2b_latency: got %0d expected 8", cyc);
        else n_pass++;
        n_total++;
        if ({s, co, ovf} !== {8'h02, 1'b0, 1'b0})
            $display("FAIL b2b_result: got s=%h co=%b ovf=%b expected s=02 co=0 ovf=0", s, co, ovf);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int stray;
        issue(8'h35, 8'h4A, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({busy, done, s, co, ovf} !== 12'h000)
            $display("FAIL midreset_async: got %h expected 000", {busy, done, s, co, ovf});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        n_total++;
        if (stray !== 0) $display("FAIL midreset_no_done: got %0d active cycles expected 0", stray);
        else n_pass++;
        issue(8'h35, 8'h4A, 1'b0);
        wait_done(cyc);
        n_total++;
        if (cyc !== 8) $display("FAIL midreset_recover_latency: got %0d expected 8", cyc);
        else n_pass++;
        n_total++;
        if ({s, co, ovf} !== {8'h7F, 1'b0, 1'b0})
            $display("FAIL midreset_recover_result: got s=%h co=%b ovf=%b expected s=7f co=0 ovf=0", s, co, ovf);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial adder/subtractor that computes a WIDTH-bit sum or difference one bit per clock, LSB first. It uses a single full-adder cell and a carry flip-flop. It is the sequential counterpart of the combinational full-adder blocks: the same one-bit equation is reused over time instead of replicated in space. It sits behind a start/done handshake, so a controller can issue one operation and collect the registered result.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2 or more.
- clk  in  1  rising-edge clock; the block's single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on rising edge of clk only while idle.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  first operand; sampled with start.
- b  in  WIDTH  second operand; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; s, co and ovf are valid from this cycle.
- s  out  WIDTH  result; holds the last completed value.
- co  out  1  final carry; in sub mode, 1 means no borrow (a >= b unsigned).
- ovf  out  1  two's-complement signed overflow of the last result.

## Operation
- States: IDLE and RUN.
- IDLE with start=1 at a rising edge:
  - Load operand shift register A with a.
  - Load operand shift register B with b, or with ~b when sub=1.
  - Set the carry flop to sub.
  - Clear the bit counter.
  - Go to RUN.
- RUN, each edge:
  - sum bit = A[0]^B[0]^c.
  - c <= majority(A[0], B[0], c).
  - Shift A and B right by one.
  - Shift the sum bit into the MSB of the internal result register.
  - Increment the counter.
- On the edge that processes bit WIDTH-1:
  - Copy the internal result to s.
  - co <= final carry.
  - ovf <= carry into the MSB xor the final carry.
  - Pulse done.
  - Return to IDLE.
- s, co and ovf change only at completion. They are never disturbed mid-operation.
- start while busy is ignored. Operand or sub changes during RUN have no effect.
- start in the same cycle as done is accepted, so back-to-back operations run with no gap cycle.
- Arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits wide and terminates at WIDTH-1, with no wrap past it.

## Timing
- Reset values: state=IDLE, busy=0, done=0, s=0, co=0, ovf=0. Internal shift registers, carry and counter are also cleared.
- Reset asserted mid-operation aborts immediately and asynchronously. No done pulse follows. The previous s, co and ovf are lost (cleared).
- Counting the start edge as edge 0:
  - busy rises after edge 0.
  - Edges 1..WIDTH each process one bit.
  - done is high for exactly one cycle after edge WIDTH, and busy falls at that edge.
- Latency is WIDTH cycles from accepted start to done. Throughput is one operation per WIDTH cycles.
- done and busy are never high together.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package serial_pkg:
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - Default WIDTH constant.
- One sub-module, fa_cell: a combinational one-bit full adder with inputs a, b, ci and outputs s, co. It is instantiated once in the datapath.
- The top level holds the FSM, counter, shift registers, carry flop and output registers. Target is about 150 RTL lines.

## Test plan
- Add 8'h35+8'h4A with sub=0 -> s=8'h7F, co=0, ovf=0; done exactly 8 cycles after the start edge; busy high for those 8 cycles.
- Add 8'hFF+8'h01 -> s=8'h00, co=1, ovf=0. Add 8'h7F+8'h01 -> s=8'h80, co=0, ovf=1.
- Sub 8'h10-8'h20 -> s=8'hF0, co=0, ovf=0. Sub 8'h80-8'h01 -> s=8'h7F, co=1, ovf=1.
- Start 8'h03+8'h04, then pulse start with 8'hAA+8'h55 at cycle 3 -> second request ignored; result s=8'h07 at done; s stays 8'h00 until done.
- Back-to-back: assert start with 8'h01+8'h01 in the done cycle of a previous op -> accepted with no idle gap; next done 8 cycles later with s=8'h02.
- Assert rst at cycle 4 of an 8'h35+8'h4A add -> busy, done, s, co and ovf read 0 immediately (before the next clock edge); no done pulse ever follows; the next start after rst deasserts completes normally.
